// File: rtl/preg_free_list_if.sv
// rtl/preg_free_list_if.sv - rename-side handshake bundle for the physical-register free list
interface preg_free_list_if #(
  parameter int TAG_W = 6,
  parameter int PTR_W = 6
);
  logic             alloc_req;
  logic             alloc_gnt;
  logic [TAG_W-1:0] alloc_tag;
  logic             commit_valid;
  logic             free_valid;
  logic [TAG_W-1:0] free_tag;
  logic             flush;
  logic             empty;
  logic [PTR_W-1:0] free_count;

  modport master (
    output alloc_req, commit_valid, free_valid, free_tag, flush,
    input  alloc_gnt, alloc_tag, empty, free_count
  );

  modport slave (
    input  alloc_req, commit_valid, free_valid, free_tag, flush,
    output alloc_gnt, alloc_tag, empty, free_count
  );
endinterface

// File: rtl/preg_free_list.sv
// rtl/preg_free_list.sv - physical-register free list with speculative/committed heads and flush rollback
// Optional sticky illegal-operation flag 'err' enabled by FREELIST_ERR_EN.
module preg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int DEPTH     = NUM_PREGS - NUM_AREGS,
  parameter int TAG_W     = $clog2(NUM_PREGS),
  parameter int PTR_W     = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  preg_free_list_if.slave     fl
`ifdef FREELIST_ERR_EN
  ,
  output logic                err
`endif
);
  localparam int               IDX_W   = PTR_W - 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] chead_q, chead_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic empty;
  logic full;
  logic gnt;
  logic do_commit;
  logic do_free;

  assign empty     = (head_q == tail_q);
  // Capacity is checked against the committed head so a free can never land on a tag
  // that a flush might still hand back out.
  assign full      = ((tail_q - chead_q) == DEPTH_P);
  assign gnt       = rst_n & fl.alloc_req & ~empty & ~fl.flush;
  assign do_commit = fl.commit_valid & (chead_q != head_q);
  assign do_free   = fl.free_valid & ~full;

  assign fl.alloc_gnt  = gnt;
  assign fl.alloc_tag  = mem_q[head_q[IDX_W-1:0]];
  assign fl.empty      = empty;
  assign fl.free_count = tail_q - head_q;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    chead_d = chead_q;
    tail_d  = tail_q;

    if (do_commit) chead_d = chead_q + ONE_P;
    if (gnt)       head_d  = head_q + ONE_P;
    if (fl.flush)  head_d  = chead_d;

    if (do_free) begin
      mem_d[tail_q[IDX_W-1:0]] = fl.free_tag;
      tail_d                   = tail_q + ONE_P;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= TAG_W'(NUM_AREGS + i);
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= DEPTH_P;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
    end
  end

`ifdef FREELIST_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (fl.free_valid & full) | (fl.commit_valid & (chead_q == head_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif
endmodule

// File: tb/tb_preg_free_list.sv
// tb/tb_preg_free_list.sv - bench for preg_free_list: queue model plus directed literal checks
module tb_preg_free_list;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  preg_free_list_if #(.TAG_W(6), .PTR_W(6)) fl_if ();

`ifdef FREELIST_ERR_EN
  logic err;
  preg_free_list dut (.clk(clk), .rst_n(rst_n), .fl(fl_if), .err(err));
`else
  preg_free_list dut (.clk(clk), .rst_n(rst_n), .fl(fl_if));
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: tags from the committed head to the tail, oldest first; the first nspec are
  // handed out but not yet committed.
  int fl_q[$];
  int nspec;
  bit m_emp, m_full, m_gnt, m_com;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_q.delete();
      for (int i = 0; i < 32; i++) fl_q.push_back(32 + i);
      nspec = 0;
    end else begin
      m_emp  = (nspec == fl_q.size());
      m_full = (fl_q.size() == 32);
      m_gnt  = fl_if.alloc_req && !m_emp && !fl_if.flush;
      m_com  = fl_if.commit_valid && (nspec > 0);
      if (m_com) begin
        void'(fl_q.pop_front());
        nspec--;
      end
      if (m_gnt) nspec++;
      if (fl_if.flush) nspec = 0;
      if (fl_if.free_valid && !m_full) fl_q.push_back(int'(fl_if.free_tag));
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("m_empty", fl_if.empty, (nspec == fl_q.size()));
      chk("m_free_count", fl_if.free_count, fl_q.size() - nspec);
      chk("m_alloc_gnt", fl_if.alloc_gnt,
          fl_if.alloc_req && (nspec != fl_q.size()) && !fl_if.flush);
      if (nspec != fl_q.size()) chk("m_alloc_tag", fl_if.alloc_tag, fl_q[nspec]);
    end
  end

  task automatic drive(input bit req, input bit cv, input bit fv, input int tag, input bit fls);
    fl_if.alloc_req    = req;
    fl_if.commit_valid = cv;
    fl_if.free_valid   = fv;
    fl_if.free_tag     = 6'(tag);
    fl_if.flush        = fls;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    chk("async_reset_free_count", fl_if.free_count, 32);
    chk("async_reset_alloc_tag", fl_if.alloc_tag, 32);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_alloc_gnt", fl_if.alloc_gnt, 0);
    chk("reset_free_count", fl_if.free_count, 32);
    chk("reset_alloc_tag", fl_if.alloc_tag, 32);
    chk("reset_empty", fl_if.empty, 0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();

    // Drain every free tag in order.
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 0, 0);
      @(negedge clk);
      chk("drain_gnt", fl_if.alloc_gnt, 1);
      chk("drain_tag", fl_if.alloc_tag, 32 + i);
      tick();
    end
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("drained_empty", fl_if.empty, 1);
    chk("drained_gnt", fl_if.alloc_gnt, 0);
    chk("drained_free_count", fl_if.free_count, 0);
    tick();
    do_reset();

    // Flush rolls the speculative head back to the committed head.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 1);
    @(negedge clk);
    chk("flush_gnt", fl_if.alloc_gnt, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_flush_tag", fl_if.alloc_tag, 34);
    chk("post_flush_free_count", fl_if.free_count, 30);
    tick();
    do_reset();

    // Free into an empty list: no bypass, tag usable next cycle.
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      drive(0, 1, 0, 0, 0);
      tick();
    end
    drive(1, 0, 1, 7, 0);
    @(negedge clk);
    chk("free_empty_gnt", fl_if.alloc_gnt, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("freed_gnt", fl_if.alloc_gnt, 1);
    chk("freed_tag", fl_if.alloc_tag, 7);
    tick();
    do_reset();

    // Steady state: first commit is illegal, first two frees hit a full list, then level.
    for (int i = 0; i < 100; i++) begin
      drive(1, 1, 1, 40, 0);
      @(negedge clk);
      if (i >= 2) chk("steady_free_count", fl_if.free_count, 30);
      tick();
    end

    // Mixed traffic with flushes landing on top of commits and frees.
    for (int i = 0; i < 60; i++) begin
      drive(i[0] | i[2], (i % 3) != 0, (i % 4) != 1, (i * 7) % 64, (i % 11) == 6);
      tick();
    end
    do_reset();

    // Illegal commit on reset must not move the committed head.
    drive(0, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ignored_commit_tag", fl_if.alloc_tag, 32);
    chk("ignored_commit_free_count", fl_if.free_count, 32);
    tick();

`ifdef FREELIST_ERR_EN
    do_reset();
    @(negedge clk);
    chk("err_reset", err, 0);
    tick();
    drive(0, 0, 1, 5, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("err_free_full", err, 1);
    chk("err_free_full_count", fl_if.free_count, 32);
    tick();
    repeat (3) tick();
    @(negedge clk);
    chk("err_sticky", err, 1);
    tick();
    do_reset();
    @(negedge clk);
    chk("err_cleared", err, 0);
    tick();
    drive(0, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("err_commit_empty", err, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("err_commit_chead", fl_if.alloc_tag, 32);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/preg_free_list.md
Name: preg_free_list

Overview:
- Physical-register free-list allocator for the out-of-order core's rename stage.
- Hands out free physical register tags to rename, one per cycle.
- Tracks which allocations have committed, and takes back tags released at retirement.
- On a pipeline flush, rolls back speculative allocations in one cycle by restoring the speculative head to the committed head.

Parameters:
- NUM_PREGS, 64, total physical registers.
- NUM_AREGS, 32, architectural registers; pregs 0..NUM_AREGS-1 are mapped at reset.
- DEPTH, NUM_PREGS-NUM_AREGS, list capacity; must be a power of two.
- TAG_W, $clog2(NUM_PREGS), tag width.
- PTR_W, $clog2(DEPTH)+1, pointer width including the wrap bit.

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_req  in  1  rename requests one tag this cycle.
- alloc_gnt  out  1  tag granted this cycle; combinational.
- alloc_tag  out  TAG_W  tag at the speculative head; meaningful when alloc_gnt=1.
- commit_valid  in  1  oldest outstanding allocation has committed.
- free_valid  in  1  retirement releases a tag.
- free_tag  in  TAG_W  released tag.
- flush  in  1  discard all uncommitted allocations.
- empty  out  1  no tag available at the speculative head.
- free_count  out  PTR_W  entries between head and tail.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Storage:
  - DEPTH x TAG_W array.
  - Three PTR_W pointers: head (speculative), chead (committed), tail.
  - Array index = pointer[PTR_W-2:0]; MSB is the wrap bit.
- Reset (async, rst_n=0):
  - head=0, chead=0, tail=DEPTH (wrap bit 1, index 0).
  - mem[i]=NUM_AREGS+i.
  - Resulting outputs: empty=0, free_count=DEPTH, alloc_tag=NUM_AREGS, alloc_gnt=0 while rst_n=0.
- Derived values:
  - free_count=tail-head (mod 2^PTR_W).
  - empty=(head==tail).
  - full=(tail-chead==DEPTH).
  - alloc_tag=mem[head idx].
- Allocate:
  - alloc_gnt = alloc_req & ~empty & ~flush.
  - On gnt, head<=head+1 next edge.
  - Zero-latency grant; tag valid in the same cycle as the request.
- Commit:
  - If commit_valid and chead!=head, chead<=chead+1.
  - commit_valid with chead==head is illegal and ignored.
- Free:
  - If free_valid and ~full, mem[tail idx]<=free_tag and tail<=tail+1.
  - Free when full is illegal; the write is dropped.
- Flush:
  - head<=chead_next, where chead_next includes a commit in the same cycle.
  - Allocations are suppressed during flush.
  - A free in the same cycle still applies.
- Simultaneous events:
  - alloc+free while empty: no grant this cycle; no bypass; freed tag is available next cycle.
  - alloc+free while not empty: both apply; free_count unchanged.
  - alloc+commit+free in one cycle: all three apply independently.
  - Freed tag written at tail never overwrites entries in [chead, tail); guaranteed by the full check against chead, not head.
- Wrap-around: all pointers increment modulo 2^PTR_W; the index wraps naturally at DEPTH.
- Reset mid-operation: asynchronously returns to the reset state; outstanding allocations are lost. The rename map resets in the same cycle.

Optional Feature:
- Macro: FREELIST_ERR_EN.
- Defined:
  - Adds output err (1 bit), reset 0.
  - err is set sticky (cleared only by rst_n) on free_valid while full, or on commit_valid while chead==head.
  - The illegal operation is still dropped.
- Undefined:
  - Port absent; illegal operations silently dropped.
  - No other behavioural difference.

Test Plan:
- Reset, no stimulus -> empty=0, free_count=32, alloc_tag=32, alloc_gnt=0.
- alloc_req=1 for 32 cycles -> tags 32..63 granted in order, one per cycle; then empty=1, alloc_gnt=0, free_count=0.
- After 5 grants (tags 32-36) and 2 commits, pulse flush with alloc_req=1 -> alloc_gnt=0 in the flush cycle; next cycle alloc_tag=34, free_count=30.
- Drain all 32 tags, commit 32, then free_tag=7 with alloc_req=1 in the same cycle -> no grant that cycle; next cycle alloc_gnt=1, alloc_tag=7.
- Steady state: alloc, commit and free (tag 40) every cycle for 100 cycles -> free_count constant; pointers wrap at least 3 times with no tag loss or duplication (scoreboard check).
- With FREELIST_ERR_EN: free_valid at reset (full) -> err=1 next cycle, free_count stays 32, err stays 1 until rst_n; commit_valid at reset -> err=1, chead unchanged.
